fazyrv_lsu_wb: RTL and testbench
================================

Name: fazyrv_lsu_wb

Overview:
- Wishbone-classic data-bus master between the core controller/fazyrv_spm_d and the data memory.
- Stores: issues the write with the lane-aligned word already produced on fazyrv_spm_d pdout_o.
- Loads: captures the bus word and presents it on fazyrv_spm_d pdin_i with a one-cycle ld_par strobe. fazyrv_spm_d then extracts, sign-extends and serialises the value.
- Also generates byte selects, detects misalignment, and reports bus errors and timeouts.

Parameters:
- TIMEOUT_CYC, 0, bus-cycle watchdog length in clk_i cycles; 0 disables the watchdog and removes the counter.
- REG_RDATA, 1, 1 = register wb_dat_i into the rdata holding register; 0 = rdata_o follows wb_dat_i combinationally during the response cycle.

Ports:
- clk_i  in  1  clock.
- rst_in  in  1  asynchronous active-low reset.
- req_i  in  1  start access; one-cycle pulse from the controller.
- we_i  in  1  1 = store, 0 = load; sampled with req_i.
- ls_b_i / ls_h_i / ls_w_i  in  1 each  access size, one-hot; sampled with req_i.
- adr_i  in  32  byte address; sampled with req_i.
- wdat_i  in  32  store data from fazyrv_spm_d pdout_o, already lane-aligned; sampled with req_i.
- rdat_o  out  32  load data to fazyrv_spm_d pdin_i.
- ld_par_o  out  1  one-cycle strobe to fazyrv_spm_d ld_par_i.
- done_o  out  1  one-cycle pulse; access finished, whatever the outcome.
- misalgn_o  out  1  qualified by done_o; misaligned access, no bus cycle issued.
- buserr_o  out  1  qualified by done_o; wb_err_i or timeout.
- busy_o  out  1  high from the cycle after req_i until done_o.
- wb_cyc_o, wb_stb_o  out  1  Wishbone cycle/strobe.
- wb_we_o  out  1  write enable.
- wb_sel_o  out  4  byte selects.
- wb_adr_o  out  32  word address; bits [1:0] forced to 0.
- wb_dat_o  out  32  write data.
- wb_dat_i  in  32  read data.
- wb_ack_i, wb_err_i  in  1  slave response.

Behaviour:
- Reset (asynchronous, rst_in=0):
  - state IDLE.
  - All outputs 0: wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o, rdat_o, ld_par_o, done_o, misalgn_o, buserr_o, busy_o.
  - Timeout counter 0.
  - A reset asserted mid-transaction drops cyc/stb immediately; no done_o is produced.
- State machine: IDLE, BUS, RESP, FIN.
- IDLE, req_i=1, aligned: latch we/sel/adr/dat, go to BUS. Wishbone outputs are registered, so cyc/stb rise in cycle N+1.
- IDLE, req_i=1, misaligned: go to FIN with misalgn_o set; no bus activity.
  - Misaligned means ls_h_i with adr_i[0]=1, or ls_w_i with adr_i[1:0]!=0.
  - ls_b_i is never misaligned.
- Byte selects:
  - ls_b_i: 4'b0001 << adr[1:0].
  - ls_h_i: 4'b0011 << {adr[1],1'b0}.
  - ls_w_i: 4'hF.
  - Loads drive the same sel as stores.
- wb_dat_o = latched wdat_i, unchanged; no lane shifting here. Holds the previous value on loads.
- BUS: cyc/stb held high and every bus output held stable until wb_ack_i or wb_err_i.
  - Response sampled at posedge: cyc/stb deassert the following cycle.
  - ack and err in the same cycle: err wins.
  - err (or timeout) goes to FIN with buserr_o set; rdat_o unchanged; no ld_par_o.
  - ack on a load: capture wb_dat_i (REG_RDATA=1), go to RESP.
  - ack on a store: go to FIN.
- Timeout (TIMEOUT_CYC>0):
  - Counter clears on entry to BUS and increments each BUS cycle without a response.
  - When it reaches TIMEOUT_CYC-1 without a response, abort as a bus error.
  - An ack arriving in the abort cycle is ignored.
- RESP: ld_par_o=1 and rdat_o valid for exactly this cycle; go to FIN. rdat_o then holds until the next load ack.
- FIN: done_o=1 for one cycle, with misalgn_o/buserr_o valid; return to IDLE. misalgn_o/buserr_o clear next cycle.
- req_i while not IDLE: ignored; not queued.
- Latencies, with req_i in cycle N:
  - Zero-wait-state load: stb at N+1, ack at N+1, ld_par_o at N+2, done_o at N+3.
  - Zero-wait-state store: done_o at N+2.
  - Misaligned access: done_o at N+1.
- busy_o = (state != IDLE).

Decomposition:
- Shared fazyrv package additions:
  - lsu_state_t enum (IDLE, BUS, RESP, FIN).
  - LSU_SEL_B/H/W base select constants.
  - Function calc_sel(size, adr_lsbs).
  - Function is_misaligned(size, adr_lsbs).
- fazyrv_spm_d reuses the same misalignment function.
- Sub-module: fazyrv_lsu_wdog (timeout counter), instantiated under a generate guard when TIMEOUT_CYC>0.

Test Plan:
- LW, adr=0x1000, wb_dat_i=0xDEADBEEF, ack on the first stb cycle -> wb_sel_o=4'hF, wb_adr_o=0x1000; ld_par_o at N+2 with rdat_o=0xDEADBEEF; done_o at N+3; misalgn_o=buserr_o=0.
- SB, adr=0x2003, wdat_i=0xAA000000, ack after 3 wait states -> wb_sel_o=4'b1000, wb_we_o=1, wb_dat_o=0xAA000000 held stable all 4 stb cycles; done_o one cycle after ack; ld_par_o never asserted.
- LH, adr=0x0001 -> no wb_cyc_o; done_o and misalgn_o at N+1. LW at adr=0x0002 behaves the same.
- LW with wb_ack_i and wb_err_i asserted together -> buserr_o=1 with done_o; ld_par_o=0; rdat_o keeps its previous value.
- TIMEOUT_CYC=8, no response -> cyc/stb high exactly 8 cycles; done_o with buserr_o one cycle after the abort cycle; a late ack in the abort cycle is ignored.
- rst_in pulled low while in BUS -> cyc/stb low in the same cycle (asynchronous); no done_o; after release, a new LB at 0x0002 gives wb_sel_o=4'b0100.

Source files
------------

// File: rtl/fazyrv_lsu_wb_pkg.sv
// Shared LSU definitions: FSM states, access sizes, byte-select and
// alignment helpers (also used by fazyrv_spm_d).
package fazyrv_lsu_wb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    RESP,
    FIN
  } lsu_state_t;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W
  } lsu_size_t;

  localparam logic [3:0] LSU_SEL_B = 4'b0001;
  localparam logic [3:0] LSU_SEL_H = 4'b0011;
  localparam logic [3:0] LSU_SEL_W = 4'b1111;

  function automatic logic [3:0] calc_sel(lsu_size_t size, logic [1:0] adr_lsbs);
    case (size)
      SZ_B:    return LSU_SEL_B << adr_lsbs;
      SZ_H:    return LSU_SEL_H << {adr_lsbs[1], 1'b0};
      default: return LSU_SEL_W;
    endcase
  endfunction

  function automatic logic is_misaligned(lsu_size_t size, logic [1:0] adr_lsbs);
    case (size)
      SZ_B:    return 1'b0;
      SZ_H:    return adr_lsbs[0];
      default: return |adr_lsbs;
    endcase
  endfunction

endpackage

// File: rtl/fazyrv_lsu_wb_if.sv
// Wishbone-classic data bus between the LSU (master) and data memory (slave).
interface fazyrv_lsu_wb_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] wdat;
  logic [31:0] rdat;
  logic        ack;
  logic        err;

  modport master (output cyc, stb, we, sel, adr, wdat, input rdat, ack, err);
  modport slave  (input cyc, stb, we, sel, adr, wdat, output rdat, ack, err);
endinterface

// File: rtl/fazyrv_lsu_wdog.sv
// Bus-cycle watchdog: flags expiry after TIMEOUT_CYC unanswered BUS cycles.
module fazyrv_lsu_wdog #(
  parameter int unsigned TIMEOUT_CYC = 8
) (
  input  logic clk_i,
  input  logic rst_in,
  input  logic run_i,
  input  logic rsp_i,
  output logic expire_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      cnt <= '0;
    end else if (!run_i || rsp_i) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign expire_o = run_i && (cnt == CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/fazyrv_lsu_wb.sv
// Wishbone-classic load/store unit: issues lane-aligned stores, captures load
// words for fazyrv_spm_d, and reports misalignment, bus errors and timeouts.
module fazyrv_lsu_wb
  import fazyrv_lsu_wb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 0,
  parameter bit          REG_RDATA   = 1'b1
) (
  input  logic                   clk_i,
  input  logic                   rst_in,
  input  logic                   req_i,
  input  logic                   we_i,
  input  logic                   ls_b_i,
  input  logic                   ls_h_i,
  input  logic                   ls_w_i,
  input  logic [31:0]            adr_i,
  input  logic [31:0]            wdat_i,
  output logic [31:0]            rdat_o,
  output logic                   ld_par_o,
  output logic                   done_o,
  output logic                   misalgn_o,
  output logic                   buserr_o,
  output logic                   busy_o,
  fazyrv_lsu_wb_if.master        wb
);

  lsu_state_t  state;
  lsu_size_t   size;
  logic        timeout;
  logic [31:0] rdat_q;

  always_comb begin
    case ({ls_w_i, ls_h_i, ls_b_i})
      3'b001:  size = SZ_B;
      3'b010:  size = SZ_H;
      default: size = SZ_W;
    endcase
  end

  generate
    if (TIMEOUT_CYC > 0) begin : g_wdog
      fazyrv_lsu_wdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
      ) u_wdog (
        .clk_i    (clk_i),
        .rst_in   (rst_in),
        .run_i    (state == BUS),
        .rsp_i    (wb.ack | wb.err),
        .expire_o (timeout)
      );
    end else begin : g_no_wdog
      assign timeout = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      state     <= IDLE;
      wb.cyc    <= 1'b0;
      wb.stb    <= 1'b0;
      wb.we     <= 1'b0;
      wb.sel    <= '0;
      wb.adr    <= '0;
      wb.wdat   <= '0;
      rdat_q    <= '0;
      ld_par_o  <= 1'b0;
      done_o    <= 1'b0;
      misalgn_o <= 1'b0;
      buserr_o  <= 1'b0;
    end else begin
      ld_par_o  <= 1'b0;
      done_o    <= 1'b0;
      misalgn_o <= 1'b0;
      buserr_o  <= 1'b0;
      case (state)
        IDLE: begin
          if (req_i) begin
            if (is_misaligned(size, adr_i[1:0])) begin
              state     <= FIN;
              done_o    <= 1'b1;
              misalgn_o <= 1'b1;
            end else begin
              state   <= BUS;
              wb.cyc  <= 1'b1;
              wb.stb  <= 1'b1;
              wb.we   <= we_i;
              wb.sel  <= calc_sel(size, adr_i[1:0]);
              wb.adr  <= {adr_i[31:2], 2'b00};
              if (we_i) wb.wdat <= wdat_i;
            end
          end
        end
        BUS: begin
          // Error and watchdog expiry take priority over a coincident ack.
          if (wb.err || timeout) begin
            state    <= FIN;
            wb.cyc   <= 1'b0;
            wb.stb   <= 1'b0;
            done_o   <= 1'b1;
            buserr_o <= 1'b1;
          end else if (wb.ack) begin
            wb.cyc <= 1'b0;
            wb.stb <= 1'b0;
            if (wb.we) begin
              state  <= FIN;
              done_o <= 1'b1;
            end else begin
              state    <= RESP;
              ld_par_o <= 1'b1;
              if (REG_RDATA) rdat_q <= wb.rdat;
            end
          end
        end
        RESP: begin
          state  <= FIN;
          done_o <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rdat_o = REG_RDATA ? rdat_q : wb.rdat;
  assign busy_o = (state != IDLE);

endmodule

// File: tb/tb_fazyrv_lsu_wb.sv
// Self-checking bench for fazyrv_lsu_wb (watchdog enabled, registered rdata)
// against a transaction-level timing model.
module tb_fazyrv_lsu_wb;

  logic        clk_i = 1'b0;
  logic        rst_in = 1'b0;
  logic        req_i, we_i, ls_b_i, ls_h_i, ls_w_i;
  logic [31:0] adr_i, wdat_i, rdat_o;
  logic        ld_par_o, done_o, misalgn_o, buserr_o, busy_o;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] m_rdat = '0;
  logic [31:0] m_wdat = '0;

  always #5 clk_i = ~clk_i;

  fazyrv_lsu_wb_if wb ();

  fazyrv_lsu_wb #(
    .TIMEOUT_CYC (8),
    .REG_RDATA   (1'b1)
  ) dut (
    .clk_i     (clk_i),
    .rst_in    (rst_in),
    .req_i     (req_i),
    .we_i      (we_i),
    .ls_b_i    (ls_b_i),
    .ls_h_i    (ls_h_i),
    .ls_w_i    (ls_w_i),
    .adr_i     (adr_i),
    .wdat_i    (wdat_i),
    .rdat_o    (rdat_o),
    .ld_par_o  (ld_par_o),
    .done_o    (done_o),
    .misalgn_o (misalgn_o),
    .buserr_o  (buserr_o),
    .busy_o    (busy_o),
    .wb        (wb)
  );

  task automatic drive_idle();
    req_i = 1'b0; we_i = 1'b0; ls_b_i = 1'b0; ls_h_i = 1'b0; ls_w_i = 1'b1;
    adr_i = '0; wdat_i = '0;
    wb.ack = 1'b0; wb.err = 1'b0; wb.rdat = '0;
  endtask

  // Issues one access at the current point (1 time unit after a rising edge)
  // and follows it cycle by cycle until one cycle past done.
  // sz in bytes (1/2/4); the slave answers after 'waits' stalled cycles.
  task automatic run_access(input string name, input bit we, input int sz,
                            input logic [31:0] adr, input logic [31:0] wdat,
                            input int waits, input bit err, input bit ack_too,
                            input logic [31:0] rdata, input bit spam);
    bit          mis, berr, in_bus;
    int          bus_n, t_ld, t_done, rs;
    logic [3:0]  esel;
    logic [31:0] eadr;
    mis  = (adr % sz) != 0;
    esel = 4'(((1 << sz) - 1) << (adr % 4));
    eadr = adr - (adr % 4);
    if (mis) begin
      bus_n = 0; berr = 1'b0; t_ld = -1; t_done = 1;
    end else begin
      bus_n  = (waits >= 7) ? 8 : waits + 1;
      berr   = err || (waits >= 7);
      t_ld   = (!we && !berr) ? bus_n + 1 : -1;
      t_done = (t_ld > 0) ? t_ld + 1 : bus_n + 1;
      if (we) m_wdat = wdat;
    end
    req_i = 1'b1; we_i = we; adr_i = adr; wdat_i = wdat;
    ls_b_i = (sz == 1); ls_h_i = (sz == 2); ls_w_i = (sz == 4);
    wb.ack = 1'b0; wb.err = 1'b0; wb.rdat = $urandom;
    for (int k = 1; k <= t_done + 1; k++) begin
      @(posedge clk_i); #1;
      in_bus = (k <= bus_n);
      if (k == t_ld) m_rdat = rdata;
      n_tests++;
      if (wb.cyc !== in_bus || wb.stb !== in_bus) begin
        n_fail++;
        $display("FAIL %s cyc/stb k=%0d: got %b%b want %b", name, k, wb.cyc, wb.stb, in_bus);
      end
      n_tests++;
      if (ld_par_o !== (k == t_ld)) begin
        n_fail++;
        $display("FAIL %s ld_par k=%0d: got %b want %b", name, k, ld_par_o, k == t_ld);
      end
      n_tests++;
      if (done_o !== (k == t_done) || busy_o !== (k <= t_done)) begin
        n_fail++;
        $display("FAIL %s done/busy k=%0d: got %b/%b want %b/%b", name, k, done_o, busy_o,
                 k == t_done, k <= t_done);
      end
      n_tests++;
      if (misalgn_o !== (k == t_done && mis) || buserr_o !== (k == t_done && berr)) begin
        n_fail++;
        $display("FAIL %s misalgn/buserr k=%0d: got %b/%b want %b/%b", name, k, misalgn_o,
                 buserr_o, k == t_done && mis, k == t_done && berr);
      end
      n_tests++;
      if (rdat_o !== m_rdat) begin
        n_fail++;
        $display("FAIL %s rdat k=%0d: got %h want %h", name, k, rdat_o, m_rdat);
      end
      if (in_bus) begin
        n_tests++;
        if (wb.sel !== esel || wb.adr !== eadr || wb.we !== we || wb.wdat !== m_wdat) begin
          n_fail++;
          $display("FAIL %s bus k=%0d: got sel=%b adr=%h we=%b dat=%h want sel=%b adr=%h we=%b dat=%h",
                   name, k, wb.sel, wb.adr, wb.we, wb.wdat, esel, eadr, we, m_wdat);
        end
      end
      wb.ack = 1'b0; wb.err = 1'b0; wb.rdat = $urandom;
      if (in_bus && k == waits + 1) begin
        if (err) begin
          wb.err = 1'b1; wb.ack = ack_too;
        end else begin
          wb.ack = 1'b1;
        end
        wb.rdat = rdata;
      end
      if (spam && k <= t_done) begin
        rs = $urandom_range(0, 2);
        req_i = 1'b1; we_i = $urandom; adr_i = $urandom; wdat_i = $urandom;
        ls_b_i = (rs == 0); ls_h_i = (rs == 1); ls_w_i = (rs == 2);
      end else begin
        req_i = 1'b0;
      end
    end
    req_i = 1'b0;
  endtask

  task automatic test_reset();
    drive_idle();
    rst_in = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    n_tests++;
    if ({wb.cyc, wb.stb, wb.we, wb.sel, wb.adr, wb.wdat} !== '0) begin
      n_fail++;
      $display("FAIL reset_bus: got cyc=%b stb=%b we=%b sel=%b adr=%h dat=%h want all 0",
               wb.cyc, wb.stb, wb.we, wb.sel, wb.adr, wb.wdat);
    end
    n_tests++;
    if ({rdat_o, ld_par_o, done_o, misalgn_o, buserr_o, busy_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_out: got rdat=%h ld_par=%b done=%b mis=%b err=%b busy=%b want all 0",
               rdat_o, ld_par_o, done_o, misalgn_o, buserr_o, busy_o);
    end
    rst_in = 1'b1;
    m_rdat = '0; m_wdat = '0;
    @(posedge clk_i); #1;
    n_tests++;
    if (busy_o !== 1'b0 || wb.cyc !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: got busy=%b cyc=%b want 0 0", busy_o, wb.cyc);
    end
  endtask

  task automatic test_load_word();
    run_access("lw_0x1000", 1'b0, 4, 32'h0000_1000, 32'h0, 0, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b0);
    run_access("lh_0x1006", 1'b0, 2, 32'h0000_1006, 32'h0, 1, 1'b0, 1'b0, 32'h1234_5678, 1'b0);
  endtask

  task automatic test_store_byte();
    run_access("sb_0x2003", 1'b1, 1, 32'h0000_2003, 32'hAA00_0000, 3, 1'b0, 1'b0, 32'h0, 1'b0);
    run_access("lb_keeps_wdat", 1'b0, 1, 32'h0000_2001, 32'h5555_5555, 0, 1'b0, 1'b0,
               32'hDEAD_BEEF, 1'b0);
    run_access("sh_0x2002", 1'b1, 2, 32'h0000_2002, 32'hBEEF_0000, 0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic test_misaligned();
    run_access("lh_0x0001", 1'b0, 2, 32'h0000_0001, 32'h0, 0, 1'b0, 1'b0, 32'h0, 1'b0);
    run_access("lw_0x0002", 1'b0, 4, 32'h0000_0002, 32'h0, 0, 1'b0, 1'b0, 32'h0, 1'b0);
    run_access("sw_0x0003", 1'b1, 4, 32'h0000_0003, 32'h1111_1111, 0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic test_err_and_ack();
    run_access("lw_ack_err", 1'b0, 4, 32'h0000_3000, 32'h0, 0, 1'b1, 1'b1, 32'hCAFE_F00D, 1'b0);
    run_access("sw_err_w2", 1'b1, 4, 32'h0000_3004, 32'h7777_0000, 2, 1'b1, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic test_timeout();
    run_access("lw_no_rsp", 1'b0, 4, 32'h0000_4000, 32'h0, 100, 1'b0, 1'b0, 32'h0, 1'b0);
    run_access("lw_late_ack", 1'b0, 4, 32'h0000_4004, 32'h0, 7, 1'b0, 1'b0, 32'h0BAD_0BAD, 1'b0);
    run_access("lw_last_ok", 1'b0, 4, 32'h0000_4008, 32'h0, 6, 1'b0, 1'b0, 32'h600D_600D, 1'b0);
  endtask

  task automatic test_reset_mid();
    bit seen_done;
    req_i = 1'b1; we_i = 1'b0; ls_b_i = 1'b0; ls_h_i = 1'b0; ls_w_i = 1'b1;
    adr_i = 32'h0000_1000;
    @(posedge clk_i); #1;
    req_i = 1'b0;
    n_tests++;
    if (wb.cyc !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_start: got cyc=%b want 1", wb.cyc);
    end
    @(posedge clk_i); #2;
    rst_in = 1'b0;
    #1;
    n_tests++;
    if (wb.cyc !== 1'b0 || wb.stb !== 1'b0 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_async: got cyc=%b stb=%b busy=%b want 0 0 0", wb.cyc, wb.stb, busy_o);
    end
    seen_done = 1'b0;
    repeat (2) begin
      @(posedge clk_i); #1;
      seen_done |= done_o;
    end
    rst_in = 1'b1;
    m_rdat = '0; m_wdat = '0;
    repeat (2) begin
      @(posedge clk_i); #1;
      seen_done |= done_o;
    end
    n_tests++;
    if (seen_done !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_no_done: got done seen=%b want 0", seen_done);
    end
    run_access("lb_after_rst", 1'b0, 1, 32'h0000_0002, 32'h0, 0, 1'b0, 1'b0, 32'h00AB_0000, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_access("b2b_sw", 1'b1, 4, 32'h0000_5000, 32'h0102_0304, 0, 1'b0, 1'b0, 32'h0, 1'b1);
    run_access("b2b_lw", 1'b0, 4, 32'h0000_5000, 32'h0, 0, 1'b0, 1'b0, 32'h0102_0304, 1'b1);
    run_access("b2b_lh", 1'b0, 2, 32'h0000_5003, 32'h0, 0, 1'b0, 1'b0, 32'h0, 1'b1);
    run_access("b2b_sb", 1'b1, 1, 32'h0000_5001, 32'h0000_CC00, 2, 1'b0, 1'b0, 32'h0, 1'b1);
  endtask

  task automatic test_random();
    int          sz, waits;
    logic [31:0] adr;
    for (int i = 0; i < 40; i++) begin
      sz  = 1 << $urandom_range(0, 2);
      adr = $urandom;
      if ($urandom_range(0, 1) == 1) adr = adr - (adr % sz);
      waits = ($urandom_range(0, 19) == 0) ? 9 : $urandom_range(0, 4);
      run_access("rand", $urandom_range(0, 1) == 1, sz, adr, $urandom, waits,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1, $urandom,
                 $urandom_range(0, 2) == 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "global timeout");
  end

  initial begin
    test_reset();
    test_load_word();
    test_store_byte();
    test_misaligned();
    test_err_and_ack();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
